// File: rtl/mem_stage_aligned.sv
// rtl/mem_stage_aligned.sv - MEM stage with byte-lane steering, req/gnt/rvalid bus and WB-side capture buffer
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses bypass the bus and flag misalign_o)
module mem_stage_aligned #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rstn_i,
    input  logic                halt_i,
    input  logic                valid_i,
    output logic                ack_o,
    input  logic [31:0]         instr_i,
    input  logic [XLEN-1:0]     result_i,
    input  logic [XLEN-1:0]     rs2_i,
    input  logic [XLEN-1:0]     pc_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i,
    input  logic                ack_i,
    output logic                valid_o,
    output logic [31:0]         instr_o,
    output logic [XLEN-1:0]     data_o,
    output logic                misalign_o
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

    state_t              r_state, w_next;
    logic [31:0]         r_instr;
    logic [LB-1:0]       r_off;
    logic [2:0]          r_f3;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [NB-1:0]       r_be;
    logic [XLEN-1:0]     r_wdata;
    logic [XLEN-1:0]     r_cap;
    logic                r_valid;
    logic [31:0]         r_instr_o;
    logic [XLEN-1:0]     r_data;

    logic [6:0]          w_opc;
    logic [2:0]          w_f3;
    logic [1:0]          w_size;
    logic                w_is_load, w_is_store, w_is_mem, w_is_link, w_f3_ok;
    logic                w_misalign, w_mem_op, w_slot_free, w_load;
    logic [LB-1:0]       w_off, w_off_a, w_align;
    logic [NB-1:0]       w_be;
    logic [XLEN-1:0]     w_wdata, w_rsh, w_ld, w_nxt_data;
    logic [31:0]         w_nxt_instr;
    logic [ADDR_W-1:0]   w_addr;

    assign w_opc       = instr_i[6:0];
    assign w_f3        = instr_i[14:12];
    assign w_size      = w_f3[1:0];
    assign w_is_load   = (w_opc == 7'b0000011);
    assign w_is_store  = (w_opc == 7'b0100011);
    assign w_is_mem    = w_is_load || w_is_store;
    assign w_is_link   = (w_opc == 7'b0010111) || (w_opc == 7'b1101111) || (w_opc == 7'b1100111);
    assign w_f3_ok     = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                         (w_f3 == 3'b100) || (w_f3 == 3'b101) ||
                         ((XLEN == 64) && ((w_f3 == 3'b011) || (w_f3 == 3'b110)));
    assign w_off       = result_i[LB-1:0];
    assign w_align     = LB'((1 << w_size) - 1);
    assign w_slot_free = !r_valid || ack_i;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign  = w_is_mem && w_f3_ok && ((w_off & w_align) != '0);
    assign w_off_a     = w_off;
`else
    assign w_misalign  = 1'b0;
    assign w_off_a     = w_off & ~w_align;
`endif

    assign w_mem_op = w_is_mem && !w_misalign;
    assign w_addr   = ADDR_W'(result_i) & ~ADDR_W'(NB - 1);
    // An unsupported width still issues the access, but with no lanes enabled
    assign w_be     = w_f3_ok ? NB'(((1 << (1 << w_size)) - 1) << w_off_a) : '0;
    assign w_wdata  = rs2_i << {w_off_a, 3'b000};
    assign w_rsh    = mem_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_ld = '0;
        if (!r_we) begin
            case (r_f3)
                3'b000:  w_ld = XLEN'($signed(w_rsh[7:0]));
                3'b001:  w_ld = XLEN'($signed(w_rsh[15:0]));
                3'b010:  w_ld = XLEN'($signed(w_rsh[31:0]));
                3'b011:  w_ld = (XLEN == 64) ? w_rsh : '0;
                3'b100:  w_ld = XLEN'(w_rsh[7:0]);
                3'b101:  w_ld = XLEN'(w_rsh[15:0]);
                3'b110:  w_ld = (XLEN == 64) ? XLEN'(w_rsh[31:0]) : '0;
                default: w_ld = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (valid_i && !halt_i && w_mem_op) w_next = S_REQ;
            S_REQ:  if (mem_gnt_i) w_next = S_WAIT;
            S_WAIT: if (mem_rvalid_i) w_next = w_load ? S_IDLE : S_DONE;
            S_DONE: if (w_load) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output comb: a load of the output register always coincides with ack_o
    always_comb begin
        w_load      = 1'b0;
        w_nxt_data  = '0;
        w_nxt_instr = r_instr;
        case (r_state)
            S_IDLE: if (valid_i && !halt_i && !w_mem_op && w_slot_free) begin
                w_load      = 1'b1;
                w_nxt_instr = instr_i;
                w_nxt_data  = w_misalign ? '0 : (w_is_link ? pc_i + XLEN'(4) : result_i);
            end
            S_WAIT: if (mem_rvalid_i && !halt_i && w_slot_free) begin
                w_load     = 1'b1;
                w_nxt_data = w_ld;
            end
            S_DONE: if (!halt_i && w_slot_free) begin
                w_load     = 1'b1;
                w_nxt_data = r_cap;
            end
            default: w_load = 1'b0;
        endcase
    end

    assign ack_o     = w_load;
    assign mem_req_o = (r_state == S_REQ);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_instr <= '0;
            r_off   <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_cap   <= '0;
        end else begin
            if (r_state == S_IDLE && w_next == S_REQ) begin
                r_instr <= instr_i;
                r_off   <= w_off_a;
                r_f3    <= w_f3;
                r_we    <= w_is_store;
                r_addr  <= w_addr;
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
            if (r_state == S_WAIT && mem_rvalid_i) r_cap <= w_ld;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid   <= 1'b0;
            r_instr_o <= '0;
            r_data    <= '0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_instr_o <= w_nxt_instr;
            r_data    <= w_nxt_data;
        end else if (ack_i && !halt_i) begin
            r_valid   <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign;
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i)     r_misalign <= 1'b0;
        else if (w_load) r_misalign <= (r_state == S_IDLE) && w_misalign;
    end
    assign misalign_o = r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

    assign valid_o     = r_valid;
    assign instr_o     = r_instr_o;
    assign data_o      = r_data;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_be_o    = r_be;
    assign mem_wdata_o = r_wdata;
endmodule

// File: tb/tb_mem_stage_aligned.sv
// tb/tb_mem_stage_aligned.sv - directed bench for mem_stage_aligned (XLEN=32)
module tb_mem_stage_aligned;
    logic        clk = 1'b0;
    logic        rstn_i, halt_i, valid_i, ack_o;
    logic [31:0] instr_i, result_i, rs2_i, pc_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        ack_i, valid_o;
    logic [31:0] instr_o, data_o;
    logic        misalign_o;
    int          vectors = 0;
    int          miscompares = 0;

    mem_stage_aligned #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rstn_i(rstn_i), .halt_i(halt_i), .valid_i(valid_i), .ack_o(ack_o),
        .instr_i(instr_i), .result_i(result_i), .rs2_i(rs2_i), .pc_i(pc_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .ack_i(ack_i),
        .valid_o(valid_o), .instr_o(instr_o), .data_o(data_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory access with grant in the request cycle and response one cycle later, WB slot free
    task automatic mem_op(input string tag, input logic [31:0] ins, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                          input logic [31:0] e_wdata, input logic [31:0] e_data);
        valid_i = 1'b1; instr_i = ins; result_i = addr; rs2_i = rs2;
        #1 check({tag, " ack_c0"}, ack_o, 1'b0);
        tick();
        check({tag, " req"}, mem_req_o, 1'b1);
        check({tag, " addr"}, mem_addr_o, e_addr);
        check({tag, " be"}, mem_be_o, e_be);
        check({tag, " we"}, mem_we_o, e_we);
        if (e_we) check({tag, " wdata"}, mem_wdata_o, e_wdata);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
        #1 check({tag, " req_drop"}, mem_req_o, 1'b0);
        check({tag, " ack_c2"}, ack_o, 1'b1);
        tick();
        mem_rvalid_i = 1'b0; valid_i = 1'b0;
        check({tag, " valid_c3"}, valid_o, 1'b1);
        check({tag, " data"}, data_o, e_data);
        check({tag, " instr"}, instr_o, ins);
        check({tag, " misalign"}, misalign_o, 1'b0);
    endtask

    initial begin
        rstn_i = 1'b0; halt_i = 1'b0; valid_i = 1'b0; instr_i = '0; result_i = '0;
        rs2_i = '0; pc_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; ack_i = 1'b1;
        tick(); tick();
        check("rst valid_o", valid_o, 1'b0);
        check("rst req", mem_req_o, 1'b0);
        check("rst ack_o", ack_o, 1'b0);
        check("rst data_o", data_o, 32'h0);
        check("rst be", mem_be_o, 4'h0);
        rstn_i = 1'b1;
        tick();

        mem_op("LB", 32'h00000083, 32'h1003, 32'h0, 32'h80123456, 32'h1000, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80);
        mem_op("LBU", 32'h00004083, 32'h1003, 32'h0, 32'h80123456, 32'h1000, 4'b1000, 1'b0, 32'h0, 32'h00000080);
        mem_op("SH", 32'h00209023, 32'h1002, 32'h0000BEEF, 32'hDEADBEEF, 32'h1000, 4'b1100, 1'b1, 32'hBEEF0000, 32'h0);
        mem_op("LH", 32'h00001083, 32'h1002, 32'h0, 32'h80011234, 32'h1000, 4'b1100, 1'b0, 32'h0, 32'hFFFF8001);
        mem_op("LHU", 32'h00005083, 32'h1000, 32'h0, 32'h80011234, 32'h1000, 4'b0011, 1'b0, 32'h0, 32'h00001234);
        mem_op("LW", 32'h00002083, 32'h1004, 32'h0, 32'h12345678, 32'h1004, 4'b1111, 1'b0, 32'h0, 32'h12345678);
        mem_op("LD32 unsup", 32'h00003083, 32'h1000, 32'h0, 32'hFFFFFFFF, 32'h1000, 4'b0000, 1'b0, 32'h0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        valid_i = 1'b1; instr_i = 32'h00002083; result_i = 32'h1002;
        #1 check("LW mis ack", ack_o, 1'b1);
        check("LW mis req", mem_req_o, 1'b0);
        tick();
        valid_i = 1'b0;
        check("LW mis valid", valid_o, 1'b1);
        check("LW mis data", data_o, 32'h0);
        check("LW mis flag", misalign_o, 1'b1);
        check("LW mis noreq", mem_req_o, 1'b0);
`else
        mem_op("LW mis", 32'h00002083, 32'h1002, 32'h0, 32'hCAFEF00D, 32'h1000, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D);
`endif

        // JAL at the top of the address space, then ADD, back to back
        valid_i = 1'b1; instr_i = 32'h0000006F; pc_i = 32'hFFFFFFFC; result_i = 32'h1234;
        #1 check("JAL ack", ack_o, 1'b1);
        tick();
        check("JAL valid", valid_o, 1'b1);
        check("JAL data", data_o, 32'h0);
        instr_i = 32'h00000033; result_i = 32'h55;
        #1 check("ADD ack", ack_o, 1'b1);
        tick();
        valid_i = 1'b0;
        check("ADD data", data_o, 32'h55);
        check("ADD instr", instr_o, 32'h00000033);
        tick();
        check("drain valid", valid_o, 1'b0);

        // Back-pressure: output held by WB while a load completes
        ack_i = 1'b0; valid_i = 1'b1; instr_i = 32'h00000033; result_i = 32'h11;
        tick();
        check("bp ADD data", data_o, 32'h11);
        instr_i = 32'h00002083; result_i = 32'h2000;
        tick();
        check("bp req", mem_req_o, 1'b1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        #1 check("bp ack wait", ack_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp state DONE", dut.r_state, 2'd3);
            check("bp ack hold", ack_o, 1'b0);
            check("bp data hold", data_o, 32'h11);
            tick();
        end
        ack_i = 1'b1;
        #1 check("bp ack release", ack_o, 1'b1);
        tick();
        valid_i = 1'b0;
        check("bp valid", valid_o, 1'b1);
        check("bp data", data_o, 32'h0BADF00D);

        // halt while the response arrives
        valid_i = 1'b1; instr_i = 32'h00002083; result_i = 32'h3004;
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; halt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13572468;
        #1 check("halt ack", ack_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        for (int i = 0; i < 2; i++) begin
            check("halt state DONE", dut.r_state, 2'd3);
            check("halt valid frozen", valid_o, 1'b0);
            check("halt ack frozen", ack_o, 1'b0);
            tick();
        end
        halt_i = 1'b0;
        #1 check("unhalt ack", ack_o, 1'b1);
        tick();
        valid_i = 1'b0;
        check("unhalt valid", valid_o, 1'b1);
        check("unhalt data", data_o, 32'h13572468);

        // Asynchronous reset during a request
        valid_i = 1'b1; instr_i = 32'h00002083; result_i = 32'h4000;
        tick();
        valid_i = 1'b0;
        check("rstreq req", mem_req_o, 1'b1);
        #2 rstn_i = 1'b0;
        #1 check("rstreq req drop", mem_req_o, 1'b0);
        check("rstreq state", dut.r_state, 2'd0);
        check("rstreq valid", valid_o, 1'b0);
        tick();
        rstn_i = 1'b1;
        tick();
        check("post rst req", mem_req_o, 1'b0);
        check("post rst valid", valid_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_stage_aligned.md
Name: mem_stage_aligned

Overview:
Parametrised successor of the pipeline MEM stage. It sits between EX and WB and uses valid/ack handshakes on both sides. It drives a simple req/gnt/rvalid data bus with byte-lane steering, so sub-word accesses at any offset are supported. It adds unsigned loads, XLEN=64 support and write-response waiting, and buffers a completed access while WB back-pressures.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
ADDR_W, 32, bus address width
NB (derived, not overridable), XLEN/8, byte lanes

Ports:
clk  in  1  clock
rstn_i  in  1  asynchronous active-low reset
halt_i  in  1  freeze pipeline registers
valid_i  in  1  EX holds a valid instruction
ack_o  out  1  instruction consumed from EX this cycle
instr_i  in  32  instruction
result_i  in  XLEN  ALU result / effective address
rs2_i  in  XLEN  store data
pc_i  in  XLEN  instruction PC
mem_req_o  out  1  bus request
mem_we_o  out  1  1 = write
mem_addr_o  out  ADDR_W  word-aligned address (low log2(NB) bits zero)
mem_be_o  out  NB  byte enables
mem_wdata_o  out  XLEN  lane-shifted write data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data / write response
mem_rdata_i  in  XLEN  read data
ack_i  in  1  WB consumed output
valid_o  out  1  output register valid
instr_o  out  32  output instruction
data_o  out  XLEN  output data
misalign_o  out  1  output instruction was a misaligned access

Behaviour:
- Reset: all outputs 0, FSM IDLE, capture buffer cleared; applies asynchronously at any state, and any in-flight bus transaction is abandoned.
- Slot free = !valid_o || ack_i. ack_i while valid_o=0 is ignored.
- Opcodes: LOAD 0000011, STORE 0100011, AUIPC 0010111, JAL 1101111, JALR 1100111; all others are pass-through.
- IDLE, pass-through: valid_i && slot free -> ack_o=1 same cycle; output register loaded next edge with data_o=result_i.
- IDLE, AUIPC/JAL/JALR: same handshake; data_o = pc_i+4, wraps modulo 2^XLEN.
- IDLE, LOAD/STORE: valid_i -> latch instr, address and wdata; go to REQ. ack_o stays 0; acceptance does not need a free slot.
- REQ: mem_req_o=1. addr, we, be and wdata are held stable until mem_gnt_i=1, then go to WAIT.
- WAIT: on mem_rvalid_i capture the (extracted) data. If slot free, load the output register, pulse ack_o and go to IDLE; otherwise go to DONE.
- DONE: wait for slot free, then load the output register, pulse ack_o and go to IDLE.
- Minimum memory latency: valid_i at cycle 0, req at cycle 1 with gnt, rvalid at cycle 2, valid_o at cycle 3.
- Lane steering:
  - off = result_i[log2(NB)-1:0]; size = funct3[1:0] (1, 2, 4 or 8 bytes).
  - be = ((1<<size)-1) << off.
  - wdata = rs2_i << (8*off).
  - load data = (rdata >> 8*off), truncated to size.
- funct3 for loads: 000 LB, 001 LH, 010 LW sign-extend; 100 LBU, 101 LHU zero-extend.
- XLEN=64 only: 011 LD/SD, 110 LWU.
- Unsupported funct3: load returns 0; store issues with be=0.
- Stores complete on rvalid; data_o=0.
- halt_i:
  - Freezes the output register and FSM transitions out of IDLE and DONE; ack_o is forced to 0.
  - REQ and WAIT continue to completion so no response is lost. Completion under halt goes to DONE.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: an access is misaligned when off is not a multiple of size. A misaligned access issues no bus request. It is treated as pass-through with data_o=0, and misalign_o=1 is registered alongside valid_o.
- Undefined: off is rounded down to a multiple of size before steering, and misalign_o is tied to 0.

Test Plan:
- XLEN=32, LB at 0x1003, rdata 0x80123456 -> mem_addr_o=0x1000, be=1000, data_o=0xFFFFFF80; as LBU -> 0x00000080.
- SH at 0x1002, rs2=0x0000BEEF, gnt same cycle -> be=1100, wdata=0xBEEF0000, mem_we_o=1; valid_o 3 cycles after valid_i, data_o=0.
- JAL with pc_i=0xFFFFFFFC, then ADD with result 0x55 back-to-back, ack_i held 1 -> data_o 0x00000000 then 0x55 on consecutive cycles, ack_o high both cycles.
- LW completes while valid_o=1 and ack_i=0 for 4 cycles -> FSM DONE, ack_o=0; on ack_i, output loads next edge.
- LW at 0x1002 -> macro on: no mem_req_o, misalign_o=1, data_o=0; macro off: addr 0x1000, be=1111, misalign_o=0.
- halt_i asserted in WAIT, rvalid arrives -> FSM DONE, outputs frozen; after halt_i drops and slot is free, valid_o with correct data. rstn_i low mid-REQ -> mem_req_o=0 and IDLE immediately.
